mem_access_unit: RTL and testbench

- Consumes the memory-related control fields produced by instruction decode: memread, memwrite, memsize, zeroextwb.
- Sits in the memory stage and drives the data-bus request/response handshake.
- For loads, aligns and extends the returned data. For stores, places the data on the correct byte lanes and generates the byte strobe.
- Stalls the pipeline until the bus completes.

---
 rtl/mem_access_unit_pkg.sv | 32 +++
 rtl/mem_access_unit_load_extend.sv | 28 ++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared access-size types, strobe type and size helpers
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  function automatic strobe_t size_mask(input msize_t size);
    case (size)
      MSIZE1:  size_mask = 8'h01;
      MSIZE2:  size_mask = 8'h03;
      MSIZE4:  size_mask = 8'h0F;
      MSIZE8:  size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
  endfunction

  function automatic logic is_misaligned(input msize_t size, input logic [2:0] lo);
    case (size)
      MSIZE2:  is_misaligned = lo[0];
      MSIZE4:  is_misaligned = |lo[1:0];
      MSIZE8:  is_misaligned = |lo;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// rtl/mem_access_unit_load_extend.sv - lane shift, size select and sign/zero extension of load data
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [2:0]        offset,
  input  msize_t            size,
  input  logic              zeroext,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;

  assign shifted = raw >> {offset, 3'b000};

  always_comb begin
    result = shifted;
    case (size)
      MSIZE1:  result = {{(DATA_W-8){~zeroext & shifted[7]}}, shifted[7:0]};
      MSIZE2:  result = {{(DATA_W-16){~zeroext & shifted[15]}}, shifted[15:0]};
      MSIZE4:  result = {{(DATA_W-32){~zeroext & shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage bus request/response sequencer with load/store lane handling
// Optional MEM_MISALIGN_CHECK_EN adds err and completes misaligned accesses without a bus request.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        memsize,
  input  logic              zeroextwb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mau_state_t;

  mau_state_t        state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q;
  msize_t            req_size_q;
  strobe_t           req_strobe_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_write_q;
  logic              req_zext_q;
  logic [2:0]        req_off_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] load_result;
  logic              mem_op;
  logic              accept;
  logic              misaligned;
  msize_t            in_size;

  assign in_size = msize_t'(memsize);
  assign mem_op  = memread | memwrite;
  assign accept  = (state_q == IDLE) && in_valid && mem_op;

`ifdef MEM_MISALIGN_CHECK_EN
  logic err_q;
  assign misaligned = is_misaligned(in_size, addr[2:0]);
  assign err        = (state_q == DONE) && err_q;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_op) begin
            stall   = 1'b1;
            state_d = misaligned ? DONE : BUSY;
          end else begin
            out_valid = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dresp_data_ok) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Combinational handshake outputs stay quiet while reset is held.
    if (reset) begin
      stall     = 1'b0;
      out_valid = 1'b0;
    end
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .raw     (dresp_data),
    .offset  (req_off_q),
    .size    (req_size_q),
    .zeroext (req_zext_q),
    .result  (load_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      req_size_q   <= MSIZE1;
      req_strobe_q <= '0;
      req_data_q   <= '0;
      req_write_q  <= 1'b0;
      req_zext_q   <= 1'b0;
      req_off_q    <= '0;
      rdata_q      <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        // A request with both memread and memwrite is handled as a store.
        req_addr_q   <= addr;
        req_size_q   <= in_size;
        req_write_q  <= memwrite;
        req_zext_q   <= zeroextwb;
        req_off_q    <= addr[2:0];
        req_strobe_q <= memwrite ? strobe_t'(size_mask(in_size) << addr[2:0]) : '0;
        req_data_q   <= memwrite ? (wdata << {addr[2:0], 3'b000}) : '0;
        if (misaligned) rdata_q <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
        err_q        <= misaligned;
`endif
      end
      if (state_q == BUSY && dresp_data_ok) begin
        rdata_q <= req_write_q ? '0 : load_result;
      end
    end
  end

  assign dreq_valid  = (state_q == BUSY);
  assign dreq_addr   = req_addr_q;
  assign dreq_size   = req_size_q;
  assign dreq_strobe = req_strobe_q;
  assign dreq_data   = req_data_q;
  assign rdata       = (state_q == IDLE && in_valid && !mem_op) ? '0 : rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, memread, memwrite, zeroextwb;
  logic [2:0]  memsize;
  logic [63:0] addr, wdata;
  logic        stall, out_valid, dreq_valid, dresp_data_ok;
  logic [63:0] rdata, dreq_addr, dreq_data, dresp_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  busy_strobe;
  logic [63:0] busy_data, got_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .memread       (memread),
    .memwrite      (memwrite),
    .memsize       (memsize),
    .zeroextwb     (zeroextwb),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .out_valid     (out_valid),
    .rdata         (rdata),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .err           (err)
`endif
  );

  always @(negedge clk)
    if (in_valid && memread && memwrite) $warning("memread and memwrite both set; handled as store");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the DONE cycle.
  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] sz,
                        input logic zx, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rsp, input int waits);
    in_valid = 1'b1; memread = rd; memwrite = wr; memsize = sz; zeroextwb = zx; addr = a; wdata = wd;
    #1 check({tag, " accept stall"}, stall, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = '1; wdata = '1; memsize = 3'd0;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      if (k == 0) begin
        busy_strobe = dreq_strobe;
        busy_data   = dreq_data;
        check({tag, " dreq_addr"}, dreq_addr, a);
        check({tag, " dreq_size"}, dreq_size, sz);
      end else begin
        check({tag, " strobe stable"}, dreq_strobe, busy_strobe);
        check({tag, " data stable"}, dreq_data, busy_data);
      end
      check({tag, " dreq_valid busy"}, dreq_valid, 1);
      check({tag, " stall busy"}, stall, 1);
      check({tag, " out_valid busy"}, out_valid, 0);
      if (k == waits) begin
        dresp_data_ok = 1'b1;
        dresp_data    = rsp;
      end
    end
    @(posedge clk); #1;
    dresp_data_ok = 1'b0; dresp_data = '0;
    @(negedge clk);
    check({tag, " out_valid done"}, out_valid, 1);
    check({tag, " stall done"}, stall, 0);
    check({tag, " dreq_valid done"}, dreq_valid, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    check({tag, " err done"}, err, 0);
`endif
    got_rd = rdata;
    @(negedge clk);
    check({tag, " out_valid pulse ends"}, out_valid, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 0; memread = 0; memwrite = 0; memsize = 0; zeroextwb = 0;
    addr = '0; wdata = '0; dresp_data_ok = 0; dresp_data = '0;
    @(negedge clk);
    check("reset dreq_valid", dreq_valid, 0);
    check("reset dreq_addr", dreq_addr, 0);
    check("reset dreq_size", dreq_size, 0);
    check("reset dreq_strobe", dreq_strobe, 0);
    check("reset dreq_data", dreq_data, 0);
    check("reset out_valid", out_valid, 0);
    check("reset rdata", rdata, 0);
    check("reset stall", stall, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op("SD", 0, 1, MSIZE8, 0, 64'h80000010, 64'h1122334455667788, 64'h0, 2);
    check("SD strobe", busy_strobe, 64'hFF);
    check("SD data", busy_data, 64'h1122334455667788);
    check("SD rdata", got_rd, 0);

    run_op("SB", 0, 1, MSIZE1, 0, 64'h80000005, 64'hAB, 64'h0, 0);
    check("SB strobe", busy_strobe, 64'h20);
    check("SB data", busy_data, 64'h0000AB0000000000);

    run_op("LBU", 1, 0, MSIZE1, 1, 64'h80000003, 64'h0, 64'h0000000080000000, 1);
    check("LBU rdata", got_rd, 64'h80);
    run_op("LB", 1, 0, MSIZE1, 0, 64'h80000003, 64'h0, 64'h0000000080000000, 0);
    check("LB strobe", busy_strobe, 0);
    check("LB rdata", got_rd, 64'hFFFFFFFFFFFFFF80);

    in_valid = 1'b1; memread = 1'b0; memwrite = 1'b0;
    #1;
    check("nonmem out_valid", out_valid, 1);
    check("nonmem stall", stall, 0);
    check("nonmem rdata", rdata, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("nonmem no request", dreq_valid, 0);
    check("nonmem out_valid ends", out_valid, 0);

    run_op("LW", 1, 0, MSIZE4, 0, 64'h80000004, 64'h0, 64'h7FFFFFFF00000000, 0);
    check("LW rdata", got_rd, 64'h000000007FFFFFFF);
    run_op("LWU", 1, 0, MSIZE4, 1, 64'h80000004, 64'h0, 64'h8000000000000000, 0);
    check("LWU rdata", got_rd, 64'h0000000080000000);
    run_op("LWneg", 1, 0, MSIZE4, 0, 64'h80000004, 64'h0, 64'h8000000000000000, 0);
    check("LWneg rdata", got_rd, 64'hFFFFFFFF80000000);
    run_op("LH", 1, 0, MSIZE2, 0, 64'h80000006, 64'h0, 64'h8001000000000000, 0);
    check("LH rdata", got_rd, 64'hFFFFFFFFFFFF8001);

    dresp_data_ok = 1'b1; dresp_data = 64'hDEADBEEFDEADBEEF;
    @(posedge clk); #1 dresp_data_ok = 1'b0; dresp_data = '0;
    @(negedge clk);
    check("idle data_ok ignored rdata", rdata, 64'hFFFFFFFFFFFF8001);
    check("idle data_ok ignored out_valid", out_valid, 0);

    in_valid = 1'b1; memread = 1'b1; memsize = MSIZE8; addr = 64'h40;
    @(posedge clk); #1 in_valid = 1'b0; memread = 1'b0;
    @(posedge clk); #1;
    check("rst busy2 dreq_valid", dreq_valid, 1);
    reset = 1'b1;
    #1;
    check("rst async dreq_valid", dreq_valid, 0);
    check("rst async stall", stall, 0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post reset out_valid", out_valid, 0);
      check("post reset dreq_valid", dreq_valid, 0);
    end
    run_op("LD", 1, 0, MSIZE8, 0, 64'h80000008, 64'h0, 64'h0123456789ABCDEF, 0);
    check("LD rdata", got_rd, 64'h0123456789ABCDEF);

    in_valid = 1'b1; memread = 1'b1; memsize = MSIZE8; addr = 64'h100;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    dresp_data_ok = 1'b1; dresp_data = 64'h5555AAAA5555AAAA;
    @(posedge clk); #1 dresp_data_ok = 1'b0;
    in_valid = 1'b1; addr = 64'h200;
    @(negedge clk);
    check("b2b done out_valid", out_valid, 1);
    check("b2b done no stall", stall, 0);
    check("b2b rdata", rdata, 64'h5555AAAA5555AAAA);
    @(negedge clk);
    check("b2b idle stall", stall, 1);
    check("b2b not yet busy", dreq_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0; memread = 1'b0;
    @(negedge clk);
    check("b2b busy", dreq_valid, 1);
    check("b2b addr", dreq_addr, 64'h200);
    dresp_data_ok = 1'b1;
    @(posedge clk); #1 dresp_data_ok = 1'b0;
    @(negedge clk);
    check("b2b second done", out_valid, 1);
    @(negedge clk);

`ifdef MEM_MISALIGN_CHECK_EN
    in_valid = 1'b1; memread = 1'b1; memsize = MSIZE4; zeroextwb = 1'b0; addr = 64'h80000002;
    #1 check("mis accept stall", stall, 1);
    @(posedge clk); #1 in_valid = 1'b0; memread = 1'b0;
    @(negedge clk);
    check("mis no request", dreq_valid, 0);
    check("mis out_valid", out_valid, 1);
    check("mis err", err, 1);
    check("mis rdata", rdata, 0);
    @(negedge clk);
    check("mis err clears", err, 0);
    check("mis out_valid clears", out_valid, 0);
    check("mis still no request", dreq_valid, 0);
`else
    run_op("SHmis", 0, 1, MSIZE2, 0, 64'h80000007, 64'hBEEF, 64'h0, 0);
    check("SHmis strobe", busy_strobe, 64'h80);
    check("SHmis data", busy_data, 64'hEF00000000000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
